// File: rtl/dsp_pkg.sv
// Shared widths, defaults and the per-beat flag bundle for the pre-add MAC.
package dsp_pkg;

    // Default guard bits above the full product width in the accumulator.
    localparam int ACC_GUARD_DEFAULT = 4;

    // Per-beat control carried alongside the data through S1..S3.
    typedef struct packed {
        logic sub;
        logic first;
        logic last;
        logic valid;
    } beat_flags_t;

    // Pre-adder result width: one extra bit so a +/- b can never overflow.
    function automatic int preadd_w(input int w);
        return w + 1;
    endfunction

    // Full product width of a (w+1) x w signed multiply.
    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/dsp_preadd_mul.sv
// Registered inputs, pre-adder and multiplier (S1..S3) sharing one stall enable.
// Shaped to map onto a single DSP slice (A/B/C input regs, pre-add reg, M reg).
module dsp_preadd_mul
    import dsp_pkg::*;
#(
    parameter int VALUE_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  valid,
    input  logic                                  sub,
    input  logic                                  first,
    input  logic                                  last,
    input  logic signed [VALUE_WIDTH-1:0]         a,
    input  logic signed [VALUE_WIDTH-1:0]         b,
    input  logic signed [VALUE_WIDTH-1:0]         c,
    output logic signed [prod_w(VALUE_WIDTH)-1:0] prod,
    output beat_flags_t                           flags
);

    localparam int PW = preadd_w(VALUE_WIDTH);
    localparam int MW = prod_w(VALUE_WIDTH);

    // Sign-extend both operands before adding so the sum always fits.
    function automatic logic signed [PW-1:0] preadd(
        input logic signed [VALUE_WIDTH-1:0] x,
        input logic signed [VALUE_WIDTH-1:0] y,
        input logic                          s
    );
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = x;
        ye = y;
        return s ? (xe - ye) : (xe + ye);
    endfunction

    // Widen both factors to the product width so no bits are lost.
    function automatic logic signed [MW-1:0] mul_full(
        input logic signed [PW-1:0]          p,
        input logic signed [VALUE_WIDTH-1:0] m
    );
        logic signed [MW-1:0] pe;
        logic signed [MW-1:0] me;
        pe = p;
        me = m;
        return pe * me;
    endfunction

    logic signed [VALUE_WIDTH-1:0] a_p0;
    logic signed [VALUE_WIDTH-1:0] b_p0;
    logic signed [VALUE_WIDTH-1:0] c_p0;
    logic signed [VALUE_WIDTH-1:0] c_p1;
    logic signed [PW-1:0]          pre_p1;
    logic signed [MW-1:0]          prod_p2;
    beat_flags_t                   flags_p0;
    beat_flags_t                   flags_p1;
    beat_flags_t                   flags_p2;

    // Flag bundle (including valid) walks down the pipe; reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_p0 <= '0;
            flags_p1 <= '0;
            flags_p2 <= '0;
        end else if (en) begin
            flags_p0.sub   <= sub;
            flags_p0.first <= first;
            flags_p0.last  <= last;
            flags_p0.valid <= valid;
            flags_p1       <= flags_p0;
            flags_p2       <= flags_p1;
        end
    end

    // Datapath registers; contents only matter when the matching valid is set.
    always_ff @(posedge clk) begin
        if (en) begin
            // S1: input registers
            a_p0    <= a;
            b_p0    <= b;
            c_p0    <= c;
            // S2: pre-add
            pre_p1  <= preadd(a_p0, b_p0, flags_p0.sub);
            c_p1    <= c_p0;
            // S3: multiply
            prod_p2 <= mul_full(pre_p1, c_p1);
        end
    end

    assign prod  = prod_p2;
    assign flags = flags_p2;

endmodule

// File: rtl/dsp_preadd_mac.sv
// Pipelined pre-add / multiply-accumulate: sums (a +/- b) * c over a framed
// group of beats and emits the sum and term count on the closing beat.
module dsp_preadd_mac
    import dsp_pkg::*;
#(
    parameter int VALUE_WIDTH = 16,
    parameter int ACC_GUARD   = ACC_GUARD_DEFAULT,
    parameter int ACC_WIDTH   = 2 * VALUE_WIDTH + 1 + ACC_GUARD,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [VALUE_WIDTH-1:0] i_preadd_a,
    input  logic signed [VALUE_WIDTH-1:0] i_preadd_b,
    input  logic signed [VALUE_WIDTH-1:0] i_mul,
    input  logic                          i_sub,
    input  logic                          i_first,
    input  logic                          i_last,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [ACC_WIDTH-1:0]   o_out,
    output logic [CNT_WIDTH-1:0]          o_count
);

    localparam int MW = prod_w(VALUE_WIDTH);

    // Sign-extend the product to accumulator width.
    function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
        input logic signed [MW-1:0] p
    );
        logic signed [ACC_WIDTH-1:0] r;
        r = p;
        return r;
    endfunction

    logic                        en;
    logic signed [MW-1:0]        prod_p2;
    beat_flags_t                 flags_p2;
    logic signed [ACC_WIDTH-1:0] acc_p3;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic [CNT_WIDTH-1:0]        cnt_p3;
    logic [CNT_WIDTH-1:0]        cnt_nxt;
    logic                        in_group;

    // A pending result that downstream refuses freezes the whole pipe.
    assign en      = !(o_valid && !i_ready);
    assign o_ready = en;

    dsp_preadd_mul #(
        .VALUE_WIDTH(VALUE_WIDTH)
    ) u_preadd_mul (
        .clk  (i_clk),
        .rst  (i_rst),
        .en   (en),
        .valid(i_valid),
        .sub  (i_sub),
        .first(i_first),
        .last (i_last),
        .a    (i_preadd_a),
        .b    (i_preadd_b),
        .c    (i_mul),
        .prod (prod_p2),
        .flags(flags_p2)
    );

    // Next accumulator/count: restart on first or when no group is open.
    always_comb begin
        acc_nxt = acc_p3 + sext_prod(prod_p2);
        cnt_nxt = cnt_p3 + CNT_WIDTH'(1);
        if (flags_p2.first || !in_group) begin
            acc_nxt = sext_prod(prod_p2);
            cnt_nxt = CNT_WIDTH'(1);
        end
    end

    // S4: accumulate valid beats, publish on last, hold output while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_p3   <= '0;
            cnt_p3   <= '0;
            in_group <= 1'b0;
            o_valid  <= 1'b0;
            o_out    <= '0;
            o_count  <= '0;
        end else if (en) begin
            o_valid <= 1'b0;
            if (flags_p2.valid) begin
                acc_p3   <= acc_nxt;
                cnt_p3   <= cnt_nxt;
                in_group <= !flags_p2.last;
                if (flags_p2.last) begin
                    o_out   <= acc_nxt;
                    o_count <= cnt_nxt;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/dsp_preadd_mac.md
Name: dsp_preadd_mac

Overview:
- Parametrised pipelined pre-add/multiply-accumulate unit. Computes sum over a group of beats of (a ± b) * c.
- Successor to the single-shot pre-adder multiply block. Adds a per-beat add/sub mode, group accumulation with first/last framing, a term counter, and a valid/ready handshake with backpressure.
- Used by the DCT/IDCT butterflies and by the quantiser dot products in the H.263 datapath. Sized to map onto one DSP slice plus fabric accumulator.

Parameters:
- VALUE_WIDTH, 16, signed width of the a, b and c inputs.
- ACC_GUARD, 4, guard bits above the product width in the accumulator.
- ACC_WIDTH, 2*VALUE_WIDTH+1+ACC_GUARD, accumulator and output width.
- CNT_WIDTH, 8, width of the term counter.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_preadd_a  in  VALUE_WIDTH  signed pre-adder operand A
- i_preadd_b  in  VALUE_WIDTH  signed pre-adder operand B
- i_mul  in  VALUE_WIDTH  signed multiplier operand C
- i_sub  in  1  0: A+B, 1: A-B
- i_first  in  1  beat starts a new accumulation group
- i_last  in  1  beat closes the group and produces an output
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_out  out  ACC_WIDTH  signed group sum
- o_count  out  CNT_WIDTH  number of terms in the group

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset: all stage valids=0, accumulator=0, term counter=0, o_valid=0, o_out=0, o_count=0, in_group=0. o_ready=1 from the first cycle after reset.
- Handshake:
  - A beat is accepted when i_valid && o_ready.
  - o_ready = !(o_valid && !i_ready).
  - A stall freezes every pipeline stage together.
  - o_out, o_count and o_valid hold stable until accepted.
  - Beats offered while o_ready=0 are ignored.
- Pipeline stages, each advancing only when not stalled:
  - S1: register inputs and flags.
  - S2: pre-add, VALUE_WIDTH+1 bits signed, sign-extended, never overflows.
  - S3: multiply, (VALUE_WIDTH+1) x VALUE_WIDTH -> 2*VALUE_WIDTH+1 bits signed.
  - S4: accumulate and register the output.
- Latency: o_valid rises 4 cycles after the last beat is accepted, if no stall occurs.
- Bubbles (invalid stage contents) never modify the accumulator or the counter.
- Accumulate rule in S4 for a valid beat:
  - If first, or in_group=0: acc = sign-extended product, count = 1.
  - Otherwise: acc = acc + product, count = count + 1.
  - Accumulator arithmetic wraps modulo 2^ACC_WIDTH (two's complement). No saturation. The counter also wraps.
- i_first while a group is open: the partial sum is silently discarded and a new group starts with this beat.
- i_first && i_last on the same beat: single-term group; the output equals the product and count=1.
- On a last beat: load o_out=acc_new and o_count=count_new, set o_valid=1, set in_group=0.
- Non-last beats produce no output.
- Reset mid-group or mid-stall: everything clears, the partial sum is lost, and no stale output appears after reset.

Decomposition:
- Package dsp_pkg holds:
  - the width helper functions preadd_w(W)=W+1 and prod_w(W)=2W+1;
  - the default ACC_GUARD;
  - a packed struct beat_flags_t {sub, first, last, valid} carried down the pipeline.
- Sub-module dsp_preadd_mul implements S1–S3 (registered inputs, pre-add, multiply, shared stall enable). It maps onto one DSP slice.
- The top level adds S4 accumulation, the counter, framing and the handshake.

Test Plan:
- Single-term group: a=3, b=4, c=5, first=last=1 -> o_out=35, o_count=1, o_valid 4 cycles after acceptance.
- Subtract mode: a=5, b=6, c=7, sub=1, first=last=1 -> o_out=-7, o_count=1.
- 8-beat dot product, back-to-back: a=1..8, b=0, c=2, first on beat 1, last on beat 8 -> o_out=72, o_count=8, a single o_valid pulse.
- Backpressure: result 35 pending, i_ready=0 for 3 cycles while i_valid=1 -> o_ready=0; o_out stays 35; offered beats are ignored. With i_ready=1, the result is accepted and o_ready=1 on the next cycle.
- Restart and reset:
  - 3 beats of 10*1 (no last), then first=last with 2*3 -> output 6, count 1.
  - The same 3 beats followed by i_rst, then 2*3 first=last -> o_out=6; no earlier output appears.
- Wrap: ACC_WIDTH=34, 16 beats of a=32767, b=32767, c=32767 -> o_out=-2097120, o_count=16.
